lockstep_fault_manager: RTL and testbench
=========================================

# lockstep_fault_manager

Parametrised lockstep supervisor for N redundant cores. It registers a per-core bus signature and valid flag every cycle, then compares them across cores and identifies the minority core(s) by majority vote. It drives a timed recovery reset to the cores, counts retries, and locks the cores out after too many faults. It sits between the redundant core instances and the subsystem reset tree, and combines comparison and recovery sequencing in one block.

## Interface
- NUM_CORES, 3: redundant core count, 2..8.
- SIG_W, 72: per-core signature width (request and address/data fields concatenated by the integrator).
- RST_HOLD, 2: cycles core_rst_no is held low per recovery, ≥1.
- MAX_RETRIES, 3: recoveries allowed before lockout, ≥0.
- HEAL_CYCLES, 1024: consecutive clean WORKING cycles that clear the retry count, ≥1.

Ports:
- clk  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-low.
- sig_valid_i  in  NUM_CORES  bit i = core i has an active request this cycle.
- sig_i  in  NUM_CORES*SIG_W  core i signature at [i*SIG_W +: SIG_W].
- clr_i  in  1  releases lockout; level-sampled.
- core_rst_no  out  1  active-low reset to all cores.
- fault_o  out  1  high from detection until return to WORKING, and throughout LOCKED.
- trg_o  out  1  one-cycle pulse per detection.
- faulty_core_o  out  NUM_CORES  minority mask of the last detection; holds until the next detection.
- locked_o  out  1  lockout active.
- retry_cnt_o  out  $clog2(MAX_RETRIES+1)  recoveries since last heal or clear.

## Operation
- **Capture stage.**
  - While in WORKING, sig_valid_i and sig_i are registered every edge.
  - Outside WORKING, the capture registers are cleared to 0.
- **Per-core tuple.** Tuple_i = {valid_i, valid_i ? sig_i : 0}. Signatures of non-valid cores are ignored.
- **Mismatch.** Mismatch = any captured tuple differs from another. Evaluated only in WORKING.
- **Majority.**
  - agree_i = number of cores whose tuple equals tuple_i (including i itself).
  - Core i is flagged when agree_i < NUM_CORES/2+1 (integer division).
  - If no core reaches majority, all cores are flagged. For NUM_CORES=2, any mismatch flags both.
- **FSM states:** WORKING, RESET, RECOVER, LOCKED.
- **WORKING + mismatch:**
  - Latch faulty_core_o and pulse trg_o.
  - If retry_cnt == MAX_RETRIES, go to LOCKED.
  - Otherwise increment retry_cnt and go to RESET.
- **RESET:** core_rst_no=0 for exactly RST_HOLD cycles, then go to RECOVER.
- **RECOVER:** one blanking cycle with core_rst_no=1 and compare disabled. Go to WORKING and clear fault_o.
- **LOCKED:**
  - core_rst_no=0, locked_o=1, fault_o=1.
  - On clr_i=1: clear retry_cnt and locked_o, then go to RESET (full RST_HOLD pulse; fault_o stays high until WORKING).
- **clr_i outside LOCKED** is ignored.
- **Heal counter.**
  - Counts consecutive WORKING cycles without mismatch, and resets on any mismatch or on leaving WORKING.
  - On reaching HEAL_CYCLES: clear retry_cnt and restart the count.
  - Mismatch on the same edge as heal completion: detection wins; retry_cnt increments from its old value.
- **Retry counter** never exceeds MAX_RETRIES. MAX_RETRIES=0 means the first fault locks.

## Timing
- **Reset values.** While rst_i=0, all outputs are forced immediately, regardless of state:
  - core_rst_no=0, fault_o=0, trg_o=0, faulty_core_o=0, locked_o=0, retry_cnt_o=0.
  - state=WORKING; capture and heal registers cleared.
- **Reset release.** core_rst_no rises on the first clk edge after rst_i deasserts (synchronous release).
- **Detection latency.** Let inputs be sampled at edge E0.
  - The compare result is available in the E0–E1 cycle.
  - At E1: state=RESET, core_rst_no=0, trg_o=1, fault_o=1, faulty_core_o and retry_cnt_o updated.
  - trg_o falls at E2.
- **Recovery timing.**
  - core_rst_no is low from E1 until E1+RST_HOLD.
  - RECOVER occupies the cycle after E1+RST_HOLD.
  - WORKING is re-entered at E1+RST_HOLD+1; fault_o falls on the same edge.
  - The first compared inputs are those sampled at E1+RST_HOLD+1, so their result appears at E1+RST_HOLD+2.
- **Mismatches outside WORKING** (RESET, RECOVER, LOCKED) are not recorded and never retrigger.
- **All outputs are registered.** No combinational path from inputs to outputs.

## Test plan
Configuration for all scenarios: NUM_CORES=3, SIG_W=8, RST_HOLD=2, MAX_RETRIES=2, HEAL_CYCLES=16.

1. **Reset.** Hold rst_i=0 for 3 cycles with random inputs, then release -> all outputs 0 during reset; core_rst_no=1 after the first edge post-release; no trg_o.
2. **Single-core data fault.** valid=3'b111, sigs {0xA5, 0x5A, 0xA5} (cores 0, 1, 2) at E0 -> at E1: trg_o one cycle, faulty_core_o=3'b010, retry_cnt_o=1, core_rst_no low E1–E3, fault_o falls at E4.
3. **Valid and three-way faults.**
   - valid=3'b110 with equal sigs -> faulty_core_o=3'b001.
   - After recovery: valid=3'b111, sigs {0x01, 0x02, 0x03} -> faulty_core_o=3'b111.
   - Non-valid mismatching sigs with valid=3'b000 -> no fault.
4. **Lockout.** Three single-core faults with no 16-cycle clean gap.
   - Third detection -> locked_o=1, core_rst_no stuck at 0, retry_cnt_o=2.
   - clr_i=1 -> retry_cnt_o=0, a 2-cycle RESET, then WORKING.
5. **Healing.**
   - Fault (retry_cnt_o=1), then 16 clean WORKING cycles -> retry_cnt_o=0.
   - Repeat, injecting the mismatch on the edge where the count reaches 16 -> retry_cnt_o=2, no heal.
6. **Mid-operation reset and blanking.**
   - Assert rst_i during RESET -> outputs reset immediately.
   - Mismatching inputs during RECOVER -> ignored; no trg_o.

Source files
------------

// File: rtl/lockstep_fault_manager.sv
// Purpose : lockstep supervisor; majority-votes registered per-core signatures, sequences recovery resets, locks out after repeated faults.
// Latency : inputs sampled at edge E0 -> detection outputs (trg_o, fault_o, faulty_core_o, retry_cnt_o, core_rst_no) at E1; all outputs registered.
// Backpressure: none; inputs are sampled every cycle in WORKING and discarded in RESET/RECOVER/LOCKED.
//
// Ports:
//   clk, rst_i         clock; asynchronous active-low reset, synchronous release
//   sig_valid_i        per-core request valid
//   sig_i              per-core signatures, core i at [i*SIG_W +: SIG_W]
//   clr_i              releases lockout (only honoured in LOCKED)
//   core_rst_no        active-low reset to all redundant cores
//   fault_o            detection-to-WORKING and throughout LOCKED
//   trg_o              one-cycle pulse per detection
//   faulty_core_o      minority mask of the last detection
//   locked_o           lockout active
//   retry_cnt_o        recoveries since last heal or clear
module lockstep_fault_manager #(
    parameter  int NUM_CORES   = 3,
    parameter  int SIG_W       = 72,
    parameter  int RST_HOLD    = 2,
    parameter  int MAX_RETRIES = 3,
    parameter  int HEAL_CYCLES = 1024,
    localparam int RW          = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic                       clk,
    input  logic                       rst_i,
    input  logic [NUM_CORES-1:0]       sig_valid_i,
    input  logic [NUM_CORES*SIG_W-1:0] sig_i,
    input  logic                       clr_i,
    output logic                       core_rst_no,
    output logic                       fault_o,
    output logic                       trg_o,
    output logic [NUM_CORES-1:0]       faulty_core_o,
    output logic                       locked_o,
    output logic [RW-1:0]              retry_cnt_o
);

    localparam int HW  = $clog2(HEAL_CYCLES + 1);
    localparam int HDW = $clog2(RST_HOLD + 1);
    localparam int CW  = $clog2(NUM_CORES + 1);
    localparam int MAJ = NUM_CORES / 2 + 1;

    typedef enum logic [1:0] {WORKING, RESET, RECOVER, LOCKED} state_t;

    state_t                     state;
    logic [NUM_CORES-1:0]       cap_vld;
    logic [NUM_CORES*SIG_W-1:0] cap_sig;
    logic [HW-1:0]              heal_cnt;
    logic [HDW-1:0]             hold_cnt;

    logic [SIG_W:0]             tup   [NUM_CORES];
    logic [CW-1:0]              agree [NUM_CORES];
    logic [NUM_CORES-1:0]       minority;
    logic                       mismatch;
    logic                       cap_en;

    // Tuple = {valid, masked signature}; agreement count per core decides minority.
    // A core with no majority partner set is flagged, so a full split flags everyone.
    always_comb begin
        mismatch = 1'b0;
        minority = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            tup[i] = {cap_vld[i], cap_vld[i] ? cap_sig[i*SIG_W +: SIG_W] : {SIG_W{1'b0}}};
        end
        for (int i = 0; i < NUM_CORES; i++) begin
            agree[i] = '0;
            for (int j = 0; j < NUM_CORES; j++) begin
                if (tup[i] == tup[j]) begin
                    agree[i] = agree[i] + CW'(1);
                end
            end
            minority[i] = (agree[i] < CW'(MAJ));
            if (tup[i] != tup[0]) begin
                mismatch = 1'b1;
            end
        end
        mismatch = mismatch && (state == WORKING);
    end

    // Capture whenever the next cycle is a WORKING cycle, so the edge that
    // re-enters WORKING already samples the first inputs to be compared.
    assign cap_en = ((state == WORKING) && !mismatch) || (state == RECOVER);

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            state         <= WORKING;
            cap_vld       <= '0;
            cap_sig       <= '0;
            heal_cnt      <= '0;
            hold_cnt      <= '0;
            core_rst_no   <= 1'b0;
            fault_o       <= 1'b0;
            trg_o         <= 1'b0;
            faulty_core_o <= '0;
            locked_o      <= 1'b0;
            retry_cnt_o   <= '0;
        end else begin
            trg_o   <= 1'b0;
            cap_vld <= cap_en ? sig_valid_i : '0;
            cap_sig <= cap_en ? sig_i : '0;
            case (state)
                WORKING: begin
                    if (mismatch) begin
                        trg_o         <= 1'b1;
                        fault_o       <= 1'b1;
                        faulty_core_o <= minority;
                        heal_cnt      <= '0;
                        hold_cnt      <= '0;
                        core_rst_no   <= 1'b0;
                        if (retry_cnt_o == RW'(MAX_RETRIES)) begin
                            state    <= LOCKED;
                            locked_o <= 1'b1;
                        end else begin
                            state       <= RESET;
                            retry_cnt_o <= retry_cnt_o + RW'(1);
                        end
                    end else begin
                        core_rst_no <= 1'b1;
                        // Heal completion restarts the count and forgives past retries.
                        if (heal_cnt == HW'(HEAL_CYCLES - 1)) begin
                            heal_cnt    <= '0;
                            retry_cnt_o <= '0;
                        end else begin
                            heal_cnt <= heal_cnt + HW'(1);
                        end
                    end
                end
                RESET: begin
                    heal_cnt <= '0;
                    if (hold_cnt == HDW'(RST_HOLD - 1)) begin
                        state       <= RECOVER;
                        core_rst_no <= 1'b1;
                    end else begin
                        hold_cnt    <= hold_cnt + HDW'(1);
                        core_rst_no <= 1'b0;
                    end
                end
                RECOVER: begin
                    heal_cnt    <= '0;
                    state       <= WORKING;
                    fault_o     <= 1'b0;
                    core_rst_no <= 1'b1;
                end
                LOCKED: begin
                    heal_cnt    <= '0;
                    core_rst_no <= 1'b0;
                    fault_o     <= 1'b1;
                    if (clr_i) begin
                        state       <= RESET;
                        hold_cnt    <= '0;
                        locked_o    <= 1'b0;
                        retry_cnt_o <= '0;
                    end
                end
                default: begin
                    state <= WORKING;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lockstep_fault_manager.sv
module tb_lockstep_fault_manager;

    localparam int NC   = 3;
    localparam int SW   = 8;
    localparam int HOLD = 2;
    localparam int MAXR = 2;
    localparam int HEAL = 16;

    logic            clk = 1'b0;
    logic            rst_i = 1'b0;
    logic [NC-1:0]   sig_valid_i = '0;
    logic [NC*SW-1:0] sig_i = '0;
    logic            clr_i = 1'b0;
    logic            core_rst_no, fault_o, trg_o, locked_o;
    logic [NC-1:0]   faulty_core_o;
    logic [1:0]      retry_cnt_o;

    int total = 0;
    int bad   = 0;

    lockstep_fault_manager #(
        .NUM_CORES(NC), .SIG_W(SW), .RST_HOLD(HOLD),
        .MAX_RETRIES(MAXR), .HEAL_CYCLES(HEAL)
    ) dut (
        .clk(clk), .rst_i(rst_i), .sig_valid_i(sig_valid_i), .sig_i(sig_i),
        .clr_i(clr_i), .core_rst_no(core_rst_no), .fault_o(fault_o),
        .trg_o(trg_o), .faulty_core_o(faulty_core_o), .locked_o(locked_o),
        .retry_cnt_o(retry_cnt_o)
    );

    always #5 clk = ~clk;

    // {core_rst_no, fault_o, trg_o, faulty_core_o[2:0], locked_o, retry_cnt_o[1:0]}
    logic [8:0] obs;
    assign obs = {core_rst_no, fault_o, trg_o, faulty_core_o, locked_o, retry_cnt_o};

    // ---------------- reference model ----------------
    // Abstract view: m_down = edges left until compare resumes (0 = comparing),
    // m_locked = lockout, m_heal = clean compare streak, m_pv/m_ps = last sample.
    bit         m_in_reset;
    bit         m_locked;
    int         m_down, m_retry, m_heal;
    bit         m_trg;
    logic [2:0] m_faulty;
    logic [2:0] m_pv;
    logic [23:0] m_ps;

    function automatic logic [8:0] tup(input logic [2:0] v, input logic [23:0] s, input int i);
        return v[i] ? {1'b1, s[i*SW +: SW]} : 9'd0;
    endfunction

    function automatic bit differs(input logic [2:0] v, input logic [23:0] s);
        for (int i = 1; i < NC; i++)
            if (tup(v, s, i) != tup(v, s, 0)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [2:0] minority_of(input logic [2:0] v, input logic [23:0] s);
        logic [2:0] r = '0;
        for (int i = 0; i < NC; i++) begin
            int n = 0;
            for (int j = 0; j < NC; j++)
                if (tup(v, s, j) == tup(v, s, i)) n++;
            r[i] = (n < NC / 2 + 1);
        end
        return r;
    endfunction

    function automatic logic [8:0] exp_vec();
        if (m_in_reset) return 9'd0;
        return {!(m_locked || m_down > 1), (m_locked || m_down > 0), m_trg, m_faulty,
                m_locked, 2'(m_retry)};
    endfunction

    task automatic model_reset();
        m_in_reset = 1; m_locked = 0; m_down = 0; m_retry = 0; m_heal = 0;
        m_trg = 0; m_faulty = '0; m_pv = '0; m_ps = '0;
    endtask

    task automatic model_update(input logic [2:0] v, input logic [23:0] s, input logic c);
        m_in_reset = 0;
        m_trg = 0;
        if (m_locked) begin
            m_heal = 0;
            if (c) begin
                m_locked = 0; m_retry = 0; m_down = HOLD + 1;
            end
        end else if (m_down > 0) begin
            m_heal = 0;
            m_down--;
        end else if (differs(m_pv, m_ps)) begin
            m_trg = 1;
            m_faulty = minority_of(m_pv, m_ps);
            m_heal = 0;
            if (m_retry == MAXR) m_locked = 1;
            else begin
                m_retry++;
                m_down = HOLD + 1;
            end
        end else begin
            m_heal++;
            if (m_heal == HEAL) begin
                m_heal = 0; m_retry = 0;
            end
        end
        m_pv = v; m_ps = s;
    endtask

    // Drive inputs, take one edge, advance the model, settle 1 time unit.
    task automatic step(input logic [2:0] v, input logic [23:0] s, input logic c);
        sig_valid_i = v; sig_i = s; clr_i = c;
        @(posedge clk);
        if (rst_i) model_update(v, s, c);
        #1;
    endtask

    task automatic clean();
        logic [7:0] b = 8'($urandom);
        step(3'b111, {b, b, b}, 1'b0);
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        #1;
        model_reset();
        step(3'($urandom), 24'($urandom), 1'b0);
        step(3'($urandom), 24'($urandom), 1'b0);
        rst_i = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        model_reset();
        for (int k = 0; k < 3; k++) begin
            step(3'($urandom), 24'($urandom), 1'($urandom));
            total++;
            if (obs !== 9'd0) begin
                bad++; $display("FAIL reset_hold: got %b want %b", obs, 9'd0);
            end
        end
        rst_i = 1'b1;
        #1;
        total++;
        if (core_rst_no !== 1'b0) begin
            bad++; $display("FAIL reset_release_async: core_rst_no=%b want 0", core_rst_no);
        end
        clean();
        total++;
        if (obs !== 9'b1_0_0_000_0_00 || obs !== exp_vec()) begin
            bad++; $display("FAIL reset_first_edge: got %b want %b", obs, 9'b100000000);
        end
    endtask

    task automatic test_single_fault();
        logic [8:0] want [4];
        want[0] = 9'b0_1_1_010_0_01;
        want[1] = 9'b0_1_0_010_0_01;
        want[2] = 9'b1_1_0_010_0_01;
        want[3] = 9'b1_0_0_010_0_01;
        do_reset();
        repeat (3) clean();
        step(3'b111, 24'hA5_5A_A5, 1'b0);
        for (int k = 0; k < 4; k++) begin
            clean();
            total++;
            if (obs !== want[k] || obs !== exp_vec()) begin
                bad++; $display("FAIL single_fault_E%0d: got %b want %b model %b", k + 1, obs, want[k], exp_vec());
            end
        end
    endtask

    task automatic test_valid_faults();
        do_reset();
        repeat (2) clean();
        step(3'b110, {3{8'h77}}, 1'b0);
        clean();
        total++;
        if (obs !== 9'b0_1_1_001_0_01 || obs !== exp_vec()) begin
            bad++; $display("FAIL valid_fault: got %b want %b", obs, 9'b011001001);
        end
        repeat (3) clean();
        step(3'b111, 24'h03_02_01, 1'b0);
        clean();
        total++;
        if (obs !== 9'b0_1_1_111_0_10 || obs !== exp_vec()) begin
            bad++; $display("FAIL three_way: got %b want %b", obs, 9'b011111010);
        end
        repeat (3) clean();
        for (int k = 0; k < 6; k++) begin
            step(3'b000, 24'($urandom), 1'b0);
            total++;
            if (trg_o !== 1'b0 || fault_o !== 1'b0 || obs !== exp_vec()) begin
                bad++; $display("FAIL invalid_ignored: got %b want %b", obs, exp_vec());
            end
        end
    endtask

    task automatic test_lockout();
        do_reset();
        clean();
        for (int k = 1; k <= 3; k++) begin
            step(3'b111, 24'hA5_A5_5A, 1'b0);
            clean();
            total++;
            if (k < 3) begin
                if (obs !== {3'b011, 3'b001, 1'b0, 2'(k)} || obs !== exp_vec()) begin
                    bad++; $display("FAIL lock_fault%0d: got %b want %b", k, obs, {3'b011, 3'b001, 1'b0, 2'(k)});
                end
                repeat (3) clean();
            end else if (obs !== 9'b0_1_1_001_1_10 || obs !== exp_vec()) begin
                bad++; $display("FAIL lock_enter: got %b want %b", obs, 9'b011001110);
            end
        end
        repeat (4) begin
            step(3'b111, 24'hA5_A5_5A, 1'b0);
            total++;
            if (obs !== 9'b0_1_0_001_1_10 || obs !== exp_vec()) begin
                bad++; $display("FAIL lock_hold: got %b want %b", obs, 9'b010001110);
            end
        end
        step(3'b111, 24'h0, 1'b1);
        total++;
        if (obs !== 9'b0_1_0_001_0_00 || obs !== exp_vec()) begin
            bad++; $display("FAIL lock_clear: got %b want %b", obs, 9'b010001000);
        end
        clean();
        clean();
        total++;
        if (obs !== 9'b1_1_0_001_0_00 || obs !== exp_vec()) begin
            bad++; $display("FAIL lock_recover: got %b want %b", obs, 9'b110001000);
        end
        clean();
        total++;
        if (obs !== 9'b1_0_0_001_0_00 || obs !== exp_vec()) begin
            bad++; $display("FAIL lock_working: got %b want %b", obs, 9'b100001000);
        end
    endtask

    task automatic test_heal();
        do_reset();
        clean();
        step(3'b111, 24'hA5_A5_5A, 1'b0);
        repeat (4) clean();                  // E1, E1+1, E1+2, WORKING entry
        repeat (HEAL - 1) clean();
        total++;
        if (retry_cnt_o !== 2'd1 || obs !== exp_vec()) begin
            bad++; $display("FAIL heal_early: retry=%0d want 1", retry_cnt_o);
        end
        clean();
        total++;
        if (retry_cnt_o !== 2'd0 || obs !== exp_vec()) begin
            bad++; $display("FAIL heal_done: retry=%0d want 0", retry_cnt_o);
        end
        step(3'b111, 24'hA5_A5_5A, 1'b0);
        repeat (4) clean();
        repeat (HEAL - 2) clean();
        step(3'b111, 24'hA5_A5_5A, 1'b0);   // compared in the 16th clean-count cycle
        clean();
        total++;
        if (obs !== 9'b0_1_1_001_0_10 || obs !== exp_vec()) begin
            bad++; $display("FAIL heal_collision: got %b want %b", obs, 9'b011001010);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        clean();
        step(3'b111, 24'hA5_5A_A5, 1'b0);
        clean();                              // now in RESET
        rst_i = 1'b0;
        #1;
        model_reset();
        total++;
        if (obs !== 9'd0) begin
            bad++; $display("FAIL mid_reset_async: got %b want %b", obs, 9'd0);
        end
        step(3'b111, 24'hA5_5A_A5, 1'b0);
        rst_i = 1'b1;
        clean();
        total++;
        if (obs !== 9'b1_0_0_000_0_00 || obs !== exp_vec()) begin
            bad++; $display("FAIL mid_reset_release: got %b want %b", obs, 9'b100000000);
        end
        step(3'b111, 24'h5A_A5_A5, 1'b0);
        clean();                              // E1
        step(3'b111, 24'h01_02_03, 1'b0);    // samples during blanking are discarded
        step(3'b101, 24'h11_22_33, 1'b0);
        for (int k = 0; k < 4; k++) begin
            clean();
            total++;
            if (trg_o !== 1'b0 || retry_cnt_o !== 2'd1 || obs !== exp_vec()) begin
                bad++; $display("FAIL blanking: got %b want %b", obs, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            int pct = ((k / 100) % 2 == 1) ? 25 : 3;
            logic [7:0] b = 8'($urandom);
            logic [2:0] v = 3'b111;
            logic [23:0] s = {b, b, b};
            if (int'($urandom_range(0, 99)) < pct) begin
                v = 3'($urandom);
                s = 24'($urandom);
                if ($urandom_range(0, 1) == 1) s[8*$urandom_range(0, 2) +: 8] = 8'($urandom);
            end
            step(v, s, ($urandom_range(0, 7) == 0));
            total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL random_%0d: got %b want %b", k, obs, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_fault();
        test_valid_faults();
        test_lockout();
        test_heal();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
